// File: rtl/nn_pkg.sv
// Shared definitions for the neural-layer blocks.
//   BW_DEF / ACCW_DEF : default operand width and accumulator/bias width.
//   S_* / state_e     : 3-bit encoding of the layer sequencer FSM states.
//   sext_acc()        : widens an accumulator-width value by one sign bit so
//                       sum + bias can be formed without overflow.
package nn_pkg;

    localparam int BW_DEF   = 8;
    localparam int ACCW_DEF = 2 * BW_DEF + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_ACT   = S_ACT,
        ST_FIN   = S_FIN
    } state_e;

    // Sized for the package default accumulator width.
    function automatic logic signed [ACCW_DEF:0] sext_acc(input logic signed [ACCW_DEF-1:0] v);
        return {v[ACCW_DEF-1], v};
    endfunction

endpackage

// File: rtl/layer4_sched_if.sv
// Host-side bundle of the layer sequencer.
//   master : drives config writes (cfg_*, bias_*), start and x_in;
//            observes busy, done and y.
//   slave  : the sequencer side (direction-reversed).
// Handshake: start is a request sampled only while busy is low; the
// run it launches ends with a single-cycle done, in which y already
// carries the new result. There is no back-pressure on done.
interface layer4_sched_if
    import nn_pkg::*;
#(
    parameter int BW      = BW_DEF,
    parameter int NEURONS = 4
);
    localparam int NW   = $clog2(NEURONS);
    localparam int ACCW = 2 * BW + 2;

    logic                cfg_we;
    logic [NW+1:0]       cfg_addr;
    logic [BW-1:0]       cfg_wdata;
    logic                bias_we;
    logic [ACCW-1:0]     bias_wdata;
    logic                start;
    logic [4*BW-1:0]     x_in;
    logic                busy;
    logic                done;
    logic [NEURONS-1:0]  y;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, bias_we, bias_wdata, start, x_in,
        input  busy, done, y
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, bias_we, bias_wdata, start, x_in,
        output busy, done, y
    );

endinterface

// File: rtl/mac4.sv
// Four-tap signed dot-product unit with a fixed latency.
//   start_i : operands w_i/x_i are captured on this pulse.
//   done_o  : high for one cycle, LAT cycles after start_i was sampled;
//             sum_o is valid from then until the next start_i.
//   sum_o   : w0*x0 + w1*x1 + w2*x2 + w3*x3, 2*BW+2 bits signed.
module mac4 #(
    parameter int BW  = 8,
    parameter int LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [4*BW-1:0]        w_i,
    input  logic [4*BW-1:0]        x_i,
    output logic                   done_o,
    output logic signed [2*BW+1:0] sum_o
);
    localparam int SW = 2 * BW + 2;
    localparam int CW = $clog2(LAT + 1);

    logic [2*BW-1:0] prod [4];
    logic [SW-1:0]   dot;
    logic [SW-1:0]   sum_q;
    logic [CW-1:0]   cnt_q;

    // Operands are sign-extended to 2*BW before multiplying so the low
    // 2*BW bits of the product are the exact signed product.
    always_comb begin
        dot = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k] = {{BW{w_i[k*BW+BW-1]}}, w_i[k*BW +: BW]} *
                      {{BW{x_i[k*BW+BW-1]}}, x_i[k*BW +: BW]};
            dot = dot + {{2{prod[k][2*BW-1]}}, prod[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            sum_q <= dot;
            cnt_q <= CW'(LAT);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign sum_o  = sum_q;

endmodule

// File: rtl/layer4_sched.sv
// Evaluates a layer of NEURONS four-input threshold perceptrons on one
// shared mac4. Weights (NEURONS*4 x BW) and biases (NEURONS x ACCW) live
// in local register stores written through the cfg port while idle.
//   clk, rst    : clock, synchronous active-high reset (also resets mac4).
//   bus (slave) : config writes, start/x_in request, busy/done/y result.
//   dbg_state_o : current sequencer state.
// Per neuron: ISSUE (1) + WAIT (MAC_LAT) + ACT (1); FIN commits y.
module layer4_sched
    import nn_pkg::*;
#(
    parameter int BW      = BW_DEF,
    parameter int NEURONS = 4,
    parameter int MAC_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    layer4_sched_if.slave   bus,
    output state_e          dbg_state_o
);
    localparam int NW   = $clog2(NEURONS);
    localparam int ACCW = 2 * BW + 2;

    state_e                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [NEURONS-1:0]     shadow_q, shadow_d;
    logic [NEURONS-1:0]     y_q;
    logic [4*BW-1:0]        x_q;
    logic signed [ACCW-1:0] sum_q;
    logic signed [BW-1:0]   w_q [NEURONS*4];
    logic signed [ACCW-1:0] b_q [NEURONS];

    logic                   mac_start;
    logic                   mac_done;
    logic signed [ACCW-1:0] mac_sum;
    logic [4*BW-1:0]        mac_w;
    logic signed [ACCW:0]   act_sum;
    logic                   last_n;
    logic                   idle;

    assign idle   = (state_q == ST_IDLE);
    assign last_n = (n_q == NW'(NEURONS - 1));

    // Weights of the current neuron; n_q is stable through ISSUE/WAIT so
    // the mac operands do not move while a job is outstanding.
    always_comb begin
        mac_w = '0;
        for (int k = 0; k < 4; k++) begin
            mac_w[k*BW +: BW] = w_q[{n_q, 2'(k)}];
        end
    end

    // One guard bit: sum + bias cannot overflow, and zero counts as firing.
    assign act_sum = sext_acc(sum_q) + sext_acc(b_q[n_q]);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        shadow_d  = shadow_q;
        mac_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mac_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (mac_done) state_d = ST_ACT;
            end
            ST_ACT: begin
                shadow_d[n_q] = ~act_sum[ACCW];
                if (last_n) begin
                    state_d = ST_FIN;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            shadow_q <= '0;
            y_q      <= '0;
            x_q      <= '0;
            sum_q    <= '0;
            for (int i = 0; i < NEURONS * 4; i++) w_q[i] <= '0;
            for (int i = 0; i < NEURONS; i++)     b_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            shadow_q <= shadow_d;
            if (idle && bus.start)                x_q <= bus.x_in;
            if (state_q == ST_WAIT && mac_done)   sum_q <= mac_sum;
            // y is committed on entry to FIN so it appears together with done.
            if (state_q == ST_ACT && last_n)      y_q <= shadow_d;
            if (idle && bus.cfg_we)               w_q[bus.cfg_addr] <= bus.cfg_wdata;
            if (idle && bus.bias_we)              b_q[bus.cfg_addr[NW+1:2]] <= bus.bias_wdata;
        end
    end

    mac4 #(
        .BW  (BW),
        .LAT (MAC_LAT)
    ) u_mac4 (
        .clk     (clk),
        .rst     (rst),
        .start_i (mac_start),
        .w_i     (mac_w),
        .x_i     (x_q),
        .done_o  (mac_done),
        .sum_o   (mac_sum)
    );

    assign bus.busy    = ~idle;
    assign bus.done    = (state_q == ST_FIN);
    assign bus.y       = y_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer4_sched.sv
module tb_layer4_sched;
    import nn_pkg::*;

    localparam int BW      = 8;
    localparam int NEURONS = 4;
    localparam int L       = 3;
    // Negedges from the start-sampling edge to the first negedge with done
    // high; counting the start cycle and done cycle inclusively this is
    // NEURONS*(L+2)+1 cycles.
    localparam int LAT_RUN = NEURONS * (L + 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer4_sched_if #(.BW(BW), .NEURONS(NEURONS)) bus ();
    state_e dbg_state;

    layer4_sched #(.BW(BW), .NEURONS(NEURONS), .MAC_LAT(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic [NEURONS-1:0] exp_q[$];
    logic [NEURONS-1:0] exp_y;
    int n_checks = 0;
    int n_pass   = 0;
    logic signed [7:0]  mw [16];
    logic signed [17:0] mb [4];

    function automatic void clr_model();
        for (int i = 0; i < 16; i++) mw[i] = '0;
        for (int i = 0; i < 4; i++)  mb[i] = '0;
    endfunction

    function automatic logic [31:0] pack_x(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [NEURONS-1:0] model_y(logic [31:0] x);
        logic [NEURONS-1:0] r;
        logic signed [7:0]  xv;
        int acc;
        for (int n = 0; n < NEURONS; n++) begin
            acc = int'(mb[n]);
            for (int k = 0; k < 4; k++) begin
                xv  = x[k*8 +: 8];
                acc = acc + int'(mw[n*4+k]) * int'(xv);
            end
            r[n] = (acc >= 0);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.bias_we = 1'b0; bus.bias_wdata = '0; bus.start = 1'b0; bus.x_in = '0;
    endtask

    task automatic write_w(input int addr, input logic signed [7:0] v);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'(addr); bus.cfg_wdata = v;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        mw[addr] = v;
    endtask

    task automatic write_b(input int n, input logic signed [17:0] v);
        @(negedge clk);
        bus.bias_we = 1'b1; bus.cfg_addr = 4'(n * 4); bus.bias_wdata = v;
        @(negedge clk);
        bus.bias_we = 1'b0;
        mb[n] = v;
    endtask

    task automatic write_both(input int addr, input logic signed [7:0] w, input logic signed [17:0] b);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.bias_we = 1'b1; bus.cfg_addr = 4'(addr);
        bus.cfg_wdata = w; bus.bias_wdata = b;
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.bias_we = 1'b0;
        mw[addr] = w; mb[addr / 4] = b;
    endtask

    task automatic set_all_w(input logic signed [7:0] v);
        for (int i = 0; i < 16; i++) write_w(i, v);
    endtask

    // Returns at the first negedge after the edge that sampled start.
    task automatic start_run(input logic [31:0] x, input logic [NEURONS-1:0] e);
        @(negedge clk);
        bus.x_in = x; bus.start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_model();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
        n_checks++; if (bus.y !== 4'b0000) $display("FAIL reset_y: got %b expected 0000", bus.y); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
        start_run(32'($urandom), 4'b1111);
        wait_done(cyc);
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL zero_store_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    task automatic test_all_ones();
        int cyc;
        set_all_w(8'sd1);
        start_run(pack_x(1, 2, 3, 4), 4'b1111);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL ones_busy: got %b expected 1", bus.busy); else n_pass++;
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL ones_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL ones_y: got %b expected %b", bus.y, exp_y); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) $display("FAIL ones_done_pulse: got %b expected 0", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL ones_busy_end: got %b expected 0", bus.busy); else n_pass++;
    endtask

    task automatic test_threshold();
        int cyc;
        write_b(0, -18'sd10);
        write_b(1, -18'sd11);
        for (int t = 0; t < 4; t++) write_w(8 + t, -8'sd1);
        write_both(12, 8'sd1, 18'sd5);
        start_run(pack_x(1, 2, 3, 4), 4'b1001);
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL thr_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL thr_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    task automatic test_extremes();
        int cyc;
        set_all_w(-8'sd128);
        for (int n = 0; n < NEURONS; n++) write_b(n, 18'sd0);
        start_run({4{8'h80}}, 4'b1111);
        wait_done(cyc);
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL ext_pos_y: got %b expected %b", bus.y, exp_y); else n_pass++;
        for (int n = 0; n < NEURONS; n++) write_b(n, 18'sd65023);
        start_run({4{8'h7f}}, 4'b0000);
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL ext_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL ext_neg_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    task automatic test_midrun();
        int cyc;
        bit y_held;
        bit no_restart;
        set_all_w(8'sd1);
        write_b(0, -18'sd12);
        for (int n = 1; n < NEURONS; n++) write_b(n, 18'sd0);
        // bit0 is 0 with w0=1 (10-12) and would be 1 with w0=5 (14-12).
        start_run(pack_x(1, 2, 3, 4), 4'b1110);
        cyc = 0;
        y_held = 1'b1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.y !== 4'b0000) y_held = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'sd5;
            end else if (cyc == 5) begin
                bus.start = 1'b0; bus.cfg_we = 1'b0;
            end
        end
        n_checks++; if (y_held !== 1'b1) $display("FAIL mid_y_hold: got %b expected 1", y_held); else n_pass++;
        n_checks++; if (cyc != LAT_RUN) $display("FAIL mid_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL mid_y: got %b expected %b", bus.y, exp_y); else n_pass++;
        no_restart = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) no_restart = 1'b0;
        end
        n_checks++; if (no_restart !== 1'b1) $display("FAIL mid_no_restart: got %b expected 1", no_restart); else n_pass++;
        write_b(3, -18'sd20);
        start_run(pack_x(1, 2, 3, 4), 4'b0110);
        wait_done(cyc);
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL mid_dropped_write_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    task automatic test_rst_midrun();
        int cyc;
        bit quiet;
        start_run(pack_x(1, 2, 3, 4), 4'b0110);
        repeat (11) @(negedge clk);
        n_checks++; if (dbg_state !== ST_WAIT) $display("FAIL rst_pre_state: got %0d expected %0d", dbg_state, ST_WAIT); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.y !== 4'b0000) $display("FAIL rst_mid_y: got %b expected 0000", bus.y); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", bus.done); else n_pass++;
        // The aborted run produces nothing; drop its expectation.
        void'(exp_q.pop_front());
        clr_model();
        rst = 1'b0;
        bus.x_in = pack_x(-5, 7, -9, 3);
        bus.start = 1'b1;
        exp_q.push_back(4'b1111);
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL rst_restart_busy: got %b expected 1", bus.busy); else n_pass++;
        quiet = 1'b1;
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL rst_restart_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL rst_restart_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int r;
        int b;
        logic [31:0] x1;
        logic [31:0] x2;
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(16, 0)) - 8;
            b = int'($urandom_range(200, 0)) - 100;
            write_both(i, 8'(r), 18'(b));
        end
        x1 = pack_x(int'($urandom_range(16, 0)) - 8, int'($urandom_range(16, 0)) - 8,
                    int'($urandom_range(16, 0)) - 8, int'($urandom_range(16, 0)) - 8);
        x2 = pack_x(int'($urandom_range(16, 0)) - 8, int'($urandom_range(16, 0)) - 8,
                    int'($urandom_range(16, 0)) - 8, int'($urandom_range(16, 0)) - 8);
        @(negedge clk);
        bus.x_in = x1; bus.start = 1'b1;
        exp_q.push_back(model_y(x1));
        @(negedge clk);
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL b2b_first_y: got %b expected %b", bus.y, exp_y); else n_pass++;
        bus.x_in = x2;
        exp_q.push_back(model_y(x2));
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_gap: got %b expected 0", bus.busy); else n_pass++;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_second_busy: got %b expected 1", bus.busy); else n_pass++;
        wait_done(cyc);
        n_checks++; if (cyc != LAT_RUN) $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, LAT_RUN); else n_pass++;
        exp_y = exp_q.pop_front();
        n_checks++; if (bus.y !== exp_y) $display("FAIL b2b_second_y: got %b expected %b", bus.y, exp_y); else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_all_ones();
        test_threshold();
        test_extremes();
        test_midrun();
        test_rst_midrun();
        test_back_to_back();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer4_sched.md
# layer4_sched

Sequencer that time-multiplexes one shared `mac4` dot-product unit across `NEURONS` four-input perceptrons to evaluate a full layer. It holds a writable per-neuron weight and bias store, latches one input vector per run, and issues one MAC job per neuron. It applies the threshold activation `sum + bias >= 0` and commits the whole layer output vector at once. It sits between the network-level controller (or host config path) and the `mac4` datapath. It replaces per-neuron perceptron instances when area matters.

## Interface
Parameters:
- `BW`, 8: bit-width of weights and inputs (signed).
- `NEURONS`, 4: neurons in the layer. Must be ≥ 2 and a power of two.
- `NW`, `$clog2(NEURONS)`: neuron index width (derived).
- `ACCW`, `2*BW+2`: width of the `mac4` sum and of each bias (signed).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_we`, in, 1: weight write strobe.
- `cfg_addr`, in, NW+2: weight address = neuron*4 + tap.
- `cfg_wdata`, in, BW: weight value.
- `bias_we`, in, 1: bias write strobe. The neuron is selected by `cfg_addr[NW+1:2]`.
- `bias_wdata`, in, ACCW: bias value.
- `start`, in, 1: run request, sampled only in IDLE.
- `x_in`, in, 4*BW: inputs; x0 = `[BW-1:0]` … x3 = `[4*BW-1:3*BW]`.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: one-cycle pulse when `y` is updated.
- `y`, out, NEURONS: activations; bit n belongs to neuron n.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACT, FIN.
- **IDLE**
  - If `start`: latch `x_in`, set neuron counter n = 0, go to ISSUE.
  - Config writes are accepted only in IDLE.
- **ISSUE**
  - Drive `mac4` inputs with the latched x and the weights of neuron n.
  - Pulse `mac_start` for exactly one cycle. Go to WAIT.
- **WAIT**
  - Hold the `mac4` operands stable.
  - On `mac_done`, capture `sum` and go to ACT.
  - `mac_done` is ignored in every other state.
  - No timeout; any `mac4` latency L ≥ 1 is tolerated.
- **ACT**
  - Compute `shadow[n] = (sext(sum) + sext(bias[n]) >= 0)`, evaluated in ACCW+1 bits so the add never overflows. A result of exactly 0 gives 1.
  - If n == NEURONS-1, go to FIN. Otherwise n++ and go to ISSUE.
- **FIN**
  - `y <= shadow`, `done = 1` for this cycle only. Go to IDLE.
- `y` holds its previous value for the whole run. There are no partial updates.
- `start` is ignored while `busy`. A `start` held high re-triggers a new run on the first IDLE cycle.
- `cfg_we` or `bias_we` while `busy`: the write is dropped and the store is unchanged.
- `cfg_we` and `bias_we` in the same IDLE cycle: both writes are performed.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `y` = 0.
  - State = IDLE, n = 0, `mac_start` = 0.
  - All weights and biases = 0.
- `rst` mid-run: the run is aborted. Outputs take their reset values on the next edge, and a new `start` is accepted on the first cycle after `rst` deasserts. `mac4` shares `rst`.
- `start` is seen at edge k. `busy` = 1 from k+1 through the FIN cycle inclusive.
- Per neuron: ISSUE (1) + WAIT (L) + ACT (1) cycles.
- Total latency from `start` edge to `done` high = NEURONS*(L+2) + 1 cycles. `done` and the new `y` appear in the same cycle.
- A back-to-back run is possible: `start` sampled in the IDLE cycle right after FIN.
- Weight and bias writes are registered: a value written at edge k is visible to a run started at edge k+1.

## Structure
- Shared package `nn_pkg`:
  - `BW` / `ACCW` defaults.
  - FSM state encoding (3-bit localparams).
  - A `sext_acc` helper used for the bias/sum sign extension.
- The weight store is a NEURONS*4 × BW register array. The bias store is a NEURONS × ACCW array. No separate module for either.
- One sub-module: the existing `mac4` (BW = `BW`), instantiated once.

## Test plan
1. Assert `rst` for 2 cycles → `busy`/`done`/`y` = 0. Run with all stores at zero → sum 0, `y` = 4'b1111.
2. All weights = 1, biases = 0, `x_in` = (1,2,3,4) → every sum = 10, `y` = 4'b1111. `done` is a single pulse at cycle 4*(L+2)+1 after `start`.
3. Threshold boundary. All weights = 1, `x_in` = (1,2,3,4), with:
   - neuron0 bias = -10
   - neuron1 bias = -11
   - neuron2 weights = -1, bias = 0
   - neuron3 bias = +5

   → `y` = 4'b1001.
4. Width extremes, all neurons:
   - w = -128, x = -128 → sum = +65536 → `y` = 1111.
   - w = -128, x = 127, bias = +65023 → sum + bias = -1 → `y` = 0000.
5. Mid-run interference:
   - Pulse `start` again and write weight addr 0 = 5 while `busy` → no restart.
   - `y` holds its old value until FIN, and the result matches the old weights.
   - A following run uses the unchanged weight (proves the write was dropped).
6. Assert `rst` during WAIT of neuron 2 → next cycle `busy` = 0, `y` = 0, no `done`. A fresh `start` completes normally with the expected `y`.
